btpipe_rx_checker: RTL
======================

// Module: btpipe_rx_checker
// PURPOSE
//  Sink-side checker for the host->FPGA BTPipe speed test. Pops 128-bit words from the read
//  side of the P2F FIFO (w32_1024/r128_256) in the sys_clk domain. Verifies that they form a
//  modulo-2^128 incrementing sequence, the counterpart of the F2P counter generator. Reports
//  word and error counts, first-error detail and a per-window throughput figure for WireOuts.
// PARAMETERS
//  DATA_W      128          FIFO read width / pattern width
//  CNT_W       32           width of all counters
//  WINDOW_CYC  200000000    sys_clk cycles per throughput window (1 s @ 200 MHz)
//  RESYNC      1            1: after a mismatch, expected <= got+1; 0: expected <= expected+1
// PORTS
//  sys_clk        in   1       system clock; all logic on rising edge
//  rstn           in   1       synchronous active-low reset
//  start          in   1       1-cycle pulse: clear stats, begin checking
//  stop           in   1       1-cycle pulse: stop popping, drain, go idle
//  fifo_empty     in   1       P2F FIFO empty
//  fifo_rd_en     out  1       P2F FIFO read enable (registered)
//  fifo_dout      in   DATA_W  P2F FIFO data
//  fifo_valid     in   1       P2F FIFO dout valid (1-cycle read latency)
//  busy           out  1       state != IDLE
//  word_cnt       out  CNT_W   words checked since start (saturating)
//  err_cnt        out  CNT_W   mismatching words since start (saturating)
//  err_flag       out  1       sticky: err_cnt != 0
//  first_err_idx  out  CNT_W   word_cnt value (0-based index) of first mismatch
//  first_err_exp  out  32      expected[31:0] at first mismatch
//  first_err_got  out  32      fifo_dout[31:0] at first mismatch
//  rate_words     out  CNT_W   words accepted in last complete window
//  rate_stb       out  1       1-cycle pulse when rate_words updates
// BEHAVIOUR
//  Reset (rstn=0 at edge): state=IDLE; every output 0; expected=0; window counter 0.
//  States: IDLE -start-> SYNC -first beat-> CHECK -stop-> DRAIN -(rd_en=0 & valid=0)-> IDLE.
//   start in any state -> SYNC, clears all counters, first_err_*, err_flag, window; start beats stop.
//   stop in SYNC/CHECK -> DRAIN; stop in IDLE/DRAIN ignored.
//  fifo_rd_en <= 1 in next cycle iff state in {SYNC,CHECK}, !fifo_empty, no stop/start this cycle.
//   FIFO underflow protection absorbs a read on empty; only fifo_valid beats are consumed.
//  Beat = fifo_valid=1 while state != IDLE (DRAIN still checks in-flight beats).
//   SYNC beat: expected <= dout+1, word_cnt <= 1, no check, -> CHECK.
//   CHECK/DRAIN beat: word_cnt++; dout==expected -> expected <= expected+1;
//    else err_cnt++, err_flag <= 1; if err_cnt==0, capture first_err_* (idx = old word_cnt);
//    expected per RESYNC.
//  Arithmetic: expected wraps mod 2^DATA_W (all-ones -> 0 is not an error). Counters stick at
//   all-ones. Results visible the cycle after the beat.
//  Window: runs while busy. Cycle counter 0..WINDOW_CYC-1, beat counter. At the terminal cycle,
//   rate_words <= beats (incl. a beat in that cycle), rate_stb=1, both restart. Partial window
//   at stop is discarded. rate_words holds until next update or start.
//  rstn low mid-run: immediate return to reset values at that edge; a FIFO beat then in flight
//   is dropped. FIFO reset is the top level's responsibility.
// STRUCTURE
//  btpipe_defs.vh: state encodings (IDLE=0,SYNC=1,CHECK=2,DRAIN=3), default DATA_W/CNT_W,
//   shared with the F2P generator.
//  Sub-module rate_window_counter (clk, rstn, clr, en, inc -> rate, stb) holds the window logic.
//  Top level ties sys_clk/rstn(ep00wire[0]), drives start/stop from TriggerIn,
//   and reads stats over WireOut.
// TESTING
//  Sequence 0..999 after start, fifo_valid 1 cycle after rd_en -> word_cnt=1000, err_cnt=0,
//   err_flag=0.
//  Seed 2^128-2, 4 words -> no errors across wrap to 0,1; word_cnt=4.
//  0,1,2,7,8,9 with RESYNC=1 -> err_cnt=1, first_err_idx=3, exp=3, got=7; RESYNC=0 -> err_cnt=3.
//  stop with a beat in flight -> beat checked in DRAIN, busy=0 once rd_en=0 and valid=0;
//   then start -> all stats 0.
//  WINDOW_CYC=100, one beat every 2 cycles -> rate_stb every 100 cycles, rate_words=50.
//  rstn=0 mid-CHECK with fifo_empty toggling -> next-edge outputs 0, fifo_rd_en=0, state IDLE.

Source files
------------

// File: rtl/btpipe_rx_checker_pkg.sv
// Shared definitions for the BTPipe P2F receive checker: state encoding and default widths.
// The encoding matches the F2P generator so both ends report state the same way.
package btpipe_rx_checker_pkg;

    localparam int BTP_DATA_W = 128;
    localparam int BTP_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DRAIN = 2'd3
    } btp_state_t;

    // States in which new FIFO reads may be issued.
    function automatic logic is_reading(input btp_state_t s);
        return (s == ST_SYNC) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/btpipe_rx_checker_rate_window.sv
// Throughput window: counts beats over WINDOW_CYC enabled cycles and publishes the total
// with a one-cycle strobe; a partial window is discarded when enable drops.
module rate_window_counter
    import btpipe_rx_checker_pkg::*;
#(
    parameter int CNT_W      = BTP_CNT_W,
    parameter int WINDOW_CYC = 200000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] rate,
    output logic             stb
);

    localparam int               CYC_W    = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WINDOW_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CYC_W-1:0] cyc;
    logic [CNT_W-1:0] beats;
    logic [CNT_W-1:0] beats_now;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic b);
        return (b && !(&v)) ? v + CNT_ONE : v;
    endfunction

    // Includes a beat landing on the terminal cycle itself.
    assign beats_now = sat_add(beats, inc);

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cyc   <= '0;
            beats <= '0;
            rate  <= '0;
            stb   <= 1'b0;
        end else if (!en) begin
            cyc   <= '0;
            beats <= '0;
            stb   <= 1'b0;
        end else if (cyc == CYC_LAST) begin
            rate  <= beats_now;
            stb   <= 1'b1;
            cyc   <= '0;
            beats <= '0;
        end else begin
            cyc   <= cyc + CYC_ONE;
            beats <= beats_now;
            stb   <= 1'b0;
        end
    end

endmodule

// File: rtl/btpipe_rx_checker.sv
// Sink-side checker for the host->FPGA BTPipe speed test: pops 128-bit words from the P2F
// FIFO and verifies a modulo-2^DATA_W incrementing sequence, reporting counts and throughput.
module btpipe_rx_checker
    import btpipe_rx_checker_pkg::*;
#(
    parameter int DATA_W     = BTP_DATA_W,
    parameter int CNT_W      = BTP_CNT_W,
    parameter int WINDOW_CYC = 200000000,
    parameter int RESYNC     = 1
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_flag,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [31:0]       first_err_exp,
    output logic [31:0]       first_err_got,
    output logic [CNT_W-1:0]  rate_words,
    output logic              rate_stb
);

    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    btp_state_t        state;
    btp_state_t        state_nxt;
    logic [DATA_W-1:0] expected;
    logic              beat;
    logic              mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // DRAIN still consumes beats so reads issued before stop are not lost.
    assign beat     = fifo_valid && (state != ST_IDLE);
    assign mismatch = (fifo_dout != expected);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_SYNC;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (stop)      state_nxt = ST_DRAIN;
                    else if (beat) state_nxt = ST_CHECK;
                end
                ST_CHECK: begin
                    if (stop) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!fifo_rd_en && !fifo_valid) state_nxt = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) fifo_rd_en <= 1'b0;
        else       fifo_rd_en <= is_reading(state) && !fifo_empty && !stop && !start;
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn || start) begin
            expected      <= '0;
            word_cnt      <= '0;
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (beat) begin
            if (state == ST_SYNC) begin
                // First beat seeds the sequence; it cannot be wrong.
                expected <= fifo_dout + DATA_ONE;
                word_cnt <= CNT_ONE;
            end else begin
                word_cnt <= sat_inc(word_cnt);
                if (!mismatch) begin
                    expected <= expected + DATA_ONE;
                end else begin
                    err_cnt  <= sat_inc(err_cnt);
                    err_flag <= 1'b1;
                    if (err_cnt == '0) begin
                        first_err_idx <= word_cnt;
                        first_err_exp <= expected[31:0];
                        first_err_got <= fifo_dout[31:0];
                    end
                    expected <= (RESYNC != 0) ? fifo_dout + DATA_ONE : expected + DATA_ONE;
                end
            end
        end
    end

    rate_window_counter #(
        .CNT_W      (CNT_W),
        .WINDOW_CYC (WINDOW_CYC)
    ) u_rate_window (
        .clk  (sys_clk),
        .rstn (rstn),
        .clr  (start),
        .en   (busy),
        .inc  (beat),
        .rate (rate_words),
        .stb  (rate_stb)
    );

endmodule
